// File: rtl/ipif_regbank_pkg.sv
// ipif_regbank_pkg
//   Shared definitions for the IPIF register bank:
//   - byte offsets of every mapped register
//   - FSM state encoding
//   - apply_be(): merge a write word into an old word under byte enables
package ipif_regbank_pkg;

    localparam int unsigned ADDR_ID         = 32'h00;
    localparam int unsigned ADDR_SCRATCH    = 32'h04;
    localparam int unsigned ADDR_CTRL       = 32'h08;
    localparam int unsigned ADDR_STATUS     = 32'h0C;
    localparam int unsigned ADDR_IRQ_STATUS = 32'h10;
    localparam int unsigned ADDR_IRQ_ENABLE = 32'h14;

    typedef enum logic {
        ST_IDLE,
        ST_ACK
    } state_t;

    // Byte lanes whose enable is set take new_word; the rest keep old_word.
    function automatic logic [31:0] apply_be(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] result;
        for (int b = 0; b < 4; b++) begin
            result[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/ipif_regbank_irq.sv
// ipif_regbank_irq
//   Interrupt status (W1C) and enable storage plus the registered level
//   interrupt output.
// Ports:
//   aclk, areset   clock, asynchronous active-high reset
//   irq_event      per-source set pulses
//   status_we      write strobe for IRQ_STATUS (write-one-to-clear)
//   enable_we      write strobe for IRQ_ENABLE
//   wdata, be      write data and byte enables of the current access
//   irq_status     current IRQ_STATUS contents
//   irq_enable     current IRQ_ENABLE contents
//   irq            registered |(irq_status & irq_enable)
module ipif_regbank_irq
    import ipif_regbank_pkg::*;
#(
    parameter int IRQ_WIDTH = 8
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [IRQ_WIDTH-1:0] irq_event,
    input  logic                 status_we,
    input  logic                 enable_we,
    input  logic [31:0]          wdata,
    input  logic [3:0]           be,
    output logic [IRQ_WIDTH-1:0] irq_status,
    output logic [IRQ_WIDTH-1:0] irq_enable,
    output logic                 irq
);

    // Bits written as 1 under an active byte enable are the ones to clear.
    logic [IRQ_WIDTH-1:0] clr_mask;
    assign clr_mask = status_we ? IRQ_WIDTH'(apply_be(32'h0, wdata, be)) : '0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            irq_status <= '0;
            irq_enable <= '0;
            irq        <= 1'b0;
        end else begin
            // OR-ing the events in after the clear makes a same-edge set win.
            irq_status <= (irq_status & ~clr_mask) | irq_event;
            if (enable_we) begin
                irq_enable <= IRQ_WIDTH'(apply_be(32'(irq_enable), wdata, be));
            end
            irq <= |(irq_status & irq_enable);
        end
    end

endmodule

// File: rtl/ipif_regbank.sv
// ipif_regbank
//   Register bank on the IPIF side of an AXI4-Lite to IPIF bridge.
//   Map (word offsets, addr[1:0] ignored): 0x00 ID (RO), 0x04 SCRATCH (RW),
//   0x08 CTRL (RW), 0x0C STATUS (RO), 0x10 IRQ_STATUS (W1C),
//   0x14 IRQ_ENABLE (RW). Every access is acknowledged one cycle after
//   its request; unmapped addresses and writes to RO registers ack with error.
// Build option:
//   IPIF_REGBANK_STATUS_SYNC_EN  defined: status passes a two-flop
//   synchronizer before it is readable; undefined: read directly.
// Ports:
//   aclk, areset              clock, asynchronous active-high reset
//   bus2ip_addr/_wr_req/_rd_req/_data/_be   request from the bridge
//   ip2bus_data/_wrack/_rdack/_error        response to the bridge
//   ctrl                      CTRL register contents
//   status                    live status word
//   irq_event                 per-source interrupt set pulses
//   irq                       level interrupt
module ipif_regbank
    import ipif_regbank_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] ID_VALUE   = 32'h4950_0001,
    parameter logic [31:0] CTRL_RESET = 32'h0000_0000,
    parameter int          IRQ_WIDTH  = 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ADDR_WIDTH-1:0] bus2ip_addr,
    input  logic                  bus2ip_wr_req,
    input  logic                  bus2ip_rd_req,
    input  logic [31:0]           bus2ip_data,
    input  logic [3:0]            bus2ip_be,
    output logic [31:0]           ip2bus_data,
    output logic                  ip2bus_wrack,
    output logic                  ip2bus_rdack,
    output logic                  ip2bus_error,
    output logic [31:0]           ctrl,
    input  logic [31:0]           status,
    input  logic [IRQ_WIDTH-1:0]  irq_event,
    output logic                  irq
);

    state_t               state;
    logic [31:0]          scratch_q;
    logic [31:0]          ctrl_q;
    logic [31:0]          status_rd;
    logic [IRQ_WIDTH-1:0] irq_status;
    logic [IRQ_WIDTH-1:0] irq_enable;

`ifdef IPIF_REGBANK_STATUS_SYNC_EN
    logic [31:0] status_meta;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            status_meta <= '0;
            status_rd   <= '0;
        end else begin
            status_meta <= status;
            status_rd   <= status_meta;
        end
    end
`else
    assign status_rd = status;
`endif

    // Clearing the two low bits uses the whole address while ignoring them.
    logic [ADDR_WIDTH-1:0] word_addr;
    assign word_addr = bus2ip_addr & ~ADDR_WIDTH'(3);

    logic        rd_mapped;
    logic        wr_allowed;
    logic [31:0] rd_value;

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        rd_mapped  = 1'b1;
        wr_allowed = 1'b0;
        rd_value   = '0;
        case (word_addr)
            ADDR_WIDTH'(ADDR_ID):         rd_value = ID_VALUE;
            ADDR_WIDTH'(ADDR_SCRATCH): begin
                rd_value   = scratch_q;
                wr_allowed = 1'b1;
            end
            ADDR_WIDTH'(ADDR_CTRL): begin
                rd_value   = ctrl_q;
                wr_allowed = 1'b1;
            end
            ADDR_WIDTH'(ADDR_STATUS):     rd_value = status_rd;
            ADDR_WIDTH'(ADDR_IRQ_STATUS): begin
                rd_value   = 32'(irq_status);
                wr_allowed = 1'b1;
            end
            ADDR_WIDTH'(ADDR_IRQ_ENABLE): begin
                rd_value   = 32'(irq_enable);
                wr_allowed = 1'b1;
            end
            default:                      rd_mapped = 1'b0;
        endcase
    end

    // A write is only accepted in IDLE; requests seen in ACK are dropped.
    logic do_write;
    assign do_write = (state == ST_IDLE) && bus2ip_wr_req && wr_allowed;

    logic irq_status_we;
    logic irq_enable_we;
    assign irq_status_we = do_write && (word_addr == ADDR_WIDTH'(ADDR_IRQ_STATUS));
    assign irq_enable_we = do_write && (word_addr == ADDR_WIDTH'(ADDR_IRQ_ENABLE));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state        <= ST_IDLE;
            ip2bus_wrack <= 1'b0;
            ip2bus_rdack <= 1'b0;
            ip2bus_error <= 1'b0;
            ip2bus_data  <= '0;
            scratch_q    <= '0;
            ctrl_q       <= CTRL_RESET;
        end else begin
            ip2bus_wrack <= 1'b0;
            ip2bus_rdack <= 1'b0;
            ip2bus_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Write has priority; a simultaneous read is dropped.
                    if (bus2ip_wr_req) begin
                        ip2bus_wrack <= 1'b1;
                        ip2bus_error <= !wr_allowed;
                        if (do_write && word_addr == ADDR_WIDTH'(ADDR_SCRATCH)) begin
                            scratch_q <= apply_be(scratch_q, bus2ip_data, bus2ip_be);
                        end
                        if (do_write && word_addr == ADDR_WIDTH'(ADDR_CTRL)) begin
                            ctrl_q <= apply_be(ctrl_q, bus2ip_data, bus2ip_be);
                        end
                        state <= ST_ACK;
                    end else if (bus2ip_rd_req) begin
                        ip2bus_rdack <= 1'b1;
                        ip2bus_error <= !rd_mapped;
                        ip2bus_data  <= rd_value;
                        state        <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    ip2bus_data <= '0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ctrl = ctrl_q;

    ipif_regbank_irq #(
        .IRQ_WIDTH (IRQ_WIDTH)
    ) u_irq (
        .aclk       (aclk),
        .areset     (areset),
        .irq_event  (irq_event),
        .status_we  (irq_status_we),
        .enable_we  (irq_enable_we),
        .wdata      (bus2ip_data),
        .be         (bus2ip_be),
        .irq_status (irq_status),
        .irq_enable (irq_enable),
        .irq        (irq)
    );

endmodule

// File: tb/tb_ipif_regbank.sv
// tb_ipif_regbank
//   Table-driven directed vectors, hand sequences for the multi-cycle corner
//   cases, and randomized accesses checked against a register-level model.
module tb_ipif_regbank;

    localparam int          AW     = 8;
    localparam int          IW     = 8;
    localparam logic [31:0] ID_V   = 32'h4950_0001;
    localparam logic [31:0] CTRL_R = 32'hA5A5_0000;

    logic          aclk = 1'b0;
    logic          areset;
    logic [AW-1:0] bus2ip_addr;
    logic          bus2ip_wr_req;
    logic          bus2ip_rd_req;
    logic [31:0]   bus2ip_data;
    logic [3:0]    bus2ip_be;
    logic [31:0]   ip2bus_data;
    logic          ip2bus_wrack;
    logic          ip2bus_rdack;
    logic          ip2bus_error;
    logic [31:0]   ctrl;
    logic [31:0]   status;
    logic [IW-1:0] irq_event;
    logic          irq;

    int checks = 0;
    int errors = 0;

    ipif_regbank #(
        .ADDR_WIDTH (AW),
        .ID_VALUE   (ID_V),
        .CTRL_RESET (CTRL_R),
        .IRQ_WIDTH  (IW)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .bus2ip_addr   (bus2ip_addr),
        .bus2ip_wr_req (bus2ip_wr_req),
        .bus2ip_rd_req (bus2ip_rd_req),
        .bus2ip_data   (bus2ip_data),
        .bus2ip_be     (bus2ip_be),
        .ip2bus_data   (ip2bus_data),
        .ip2bus_wrack  (ip2bus_wrack),
        .ip2bus_rdack  (ip2bus_rdack),
        .ip2bus_error  (ip2bus_error),
        .ctrl          (ctrl),
        .status        (status),
        .irq_event     (irq_event),
        .irq           (irq)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (register level) ----------------
    logic [31:0]   m_scratch;
    logic [31:0]   m_ctrl;
    logic [IW-1:0] m_st;
    logic [IW-1:0] m_en;

    task automatic model_reset();
        m_scratch = '0;
        m_ctrl    = CTRL_R;
        m_st      = '0;
        m_en      = '0;
    endtask

    task automatic model_access(input bit wr, input bit rd, input logic [7:0] a,
                                input logic [31:0] d, input logic [3:0] be,
                                input logic [IW-1:0] ev,
                                output bit ew, output bit er, output bit ee,
                                output logic [31:0] ed);
        int word;
        word = int'(a) / 4;
        ew = 0; er = 0; ee = 0; ed = '0;
        if (wr) begin
            ew = 1;
            case (word)
                1: for (int b = 0; b < 4; b++) if (be[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
                2: for (int b = 0; b < 4; b++) if (be[b]) m_ctrl[8*b +: 8] = d[8*b +: 8];
                4: for (int i = 0; i < IW; i++) if (be[i/8] && d[i]) m_st[i] = 1'b0;
                5: for (int i = 0; i < IW; i++) if (be[i/8]) m_en[i] = d[i];
                default: ee = 1;
            endcase
        end else if (rd) begin
            er = 1;
            case (word)
                0: ed = ID_V;
                1: ed = m_scratch;
                2: ed = m_ctrl;
                3: ed = status;
                4: ed = {24'h0, m_st};
                5: ed = {24'h0, m_en};
                default: ee = 1;
            endcase
        end
        // New events land after any clear, so they survive it.
        for (int i = 0; i < IW; i++) if (ev[i]) m_st[i] = 1'b1;
    endtask

    // -------------- bus access: request at edge N, sample in cycle N+1 --------------
    task automatic access(input bit wr, input bit rd, input logic [7:0] a,
                          input logic [31:0] d, input logic [3:0] be,
                          input logic [IW-1:0] ev,
                          output logic wack, output logic rack,
                          output logic err, output logic [31:0] rdata);
        @(negedge aclk);
        bus2ip_wr_req = wr;
        bus2ip_rd_req = rd;
        bus2ip_addr   = a;
        bus2ip_data   = d;
        bus2ip_be     = be;
        irq_event     = ev;
        @(negedge aclk);
        bus2ip_wr_req = 1'b0;
        bus2ip_rd_req = 1'b0;
        irq_event     = '0;
        wack  = ip2bus_wrack;
        rack  = ip2bus_rdack;
        err   = ip2bus_error;
        rdata = ip2bus_data;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
    endtask

    typedef struct {
        bit          wr;
        bit          rd;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        bit          e_wrack;
        bit          e_rdack;
        bit          e_err;
        logic [31:0] e_data;
    } vec_t;

    function automatic vec_t mk(bit wr, bit rd, logic [7:0] a, logic [31:0] d, logic [3:0] be,
                                bit ew, bit er, bit ee, logic [31:0] ed);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = a; v.data = d; v.be = be;
        v.e_wrack = ew; v.e_rdack = er; v.e_err = ee; v.e_data = ed;
        return v;
    endfunction

    vec_t vecs[22];

    logic        wack, rack, err;
    logic [31:0] rdata;
    bit          ew, er, ee;
    logic [31:0] ed;

    initial begin
        bus2ip_wr_req = 1'b0;
        bus2ip_rd_req = 1'b0;
        bus2ip_addr   = '0;
        bus2ip_data   = '0;
        bus2ip_be     = '0;
        irq_event     = '0;
        status        = 32'hDEAD_BEEF;

        vecs[0]  = mk(0, 1, 8'h00, 32'h0,         4'h0, 0, 1, 0, ID_V);
        vecs[1]  = mk(1, 0, 8'h04, 32'hABCD_EF01, 4'b0101, 1, 0, 0, 32'h0);
        vecs[2]  = mk(0, 1, 8'h04, 32'h0,         4'h0, 0, 1, 0, 32'h00CD_0001);
        vecs[3]  = mk(1, 0, 8'h0C, 32'hFFFF_FFFF, 4'hF, 1, 0, 1, 32'h0);
        vecs[4]  = mk(0, 1, 8'h0C, 32'h0,         4'h0, 0, 1, 0, 32'hDEAD_BEEF);
        vecs[5]  = mk(0, 1, 8'h40, 32'h0,         4'h0, 0, 1, 1, 32'h0);
        vecs[6]  = mk(1, 0, 8'h00, 32'h1234_5678, 4'hF, 1, 0, 1, 32'h0);
        vecs[7]  = mk(0, 1, 8'h00, 32'h0,         4'h0, 0, 1, 0, ID_V);
        vecs[8]  = mk(1, 0, 8'h08, 32'hFFFF_FFFF, 4'h0, 1, 0, 0, 32'h0);
        vecs[9]  = mk(0, 1, 8'h08, 32'h0,         4'h0, 0, 1, 0, CTRL_R);
        vecs[10] = mk(1, 0, 8'h08, 32'h1234_5678, 4'b1100, 1, 0, 0, 32'h0);
        vecs[11] = mk(0, 1, 8'h08, 32'h0,         4'h0, 0, 1, 0, 32'h1234_0000);
        vecs[12] = mk(0, 1, 8'h07, 32'h0,         4'h0, 0, 1, 0, 32'h00CD_0001);
        vecs[13] = mk(1, 0, 8'h14, 32'hFFFF_FFFF, 4'b0001, 1, 0, 0, 32'h0);
        vecs[14] = mk(0, 1, 8'h14, 32'h0,         4'h0, 0, 1, 0, 32'h0000_00FF);
        vecs[15] = mk(0, 1, 8'h18, 32'h0,         4'h0, 0, 1, 1, 32'h0);
        vecs[16] = mk(1, 0, 8'h41, 32'hFFFF_FFFF, 4'hF, 1, 0, 1, 32'h0);
        vecs[17] = mk(0, 1, 8'h10, 32'h0,         4'h0, 0, 1, 0, 32'h0);
        vecs[18] = mk(1, 0, 8'h14, 32'h0,         4'b0001, 1, 0, 0, 32'h0);
        vecs[19] = mk(0, 1, 8'h14, 32'h0,         4'h0, 0, 1, 0, 32'h0);
        vecs[20] = mk(1, 0, 8'h04, 32'hFFFF_FFFF, 4'b1010, 1, 0, 0, 32'h0);
        vecs[21] = mk(0, 1, 8'h04, 32'h0,         4'h0, 0, 1, 0, 32'hFFCD_FF01);

        // ---------------- reset state ----------------
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        check("rst_wrack", 32'(ip2bus_wrack), 32'h0);
        check("rst_rdack", 32'(ip2bus_rdack), 32'h0);
        check("rst_error", 32'(ip2bus_error), 32'h0);
        check("rst_data",  ip2bus_data, 32'h0);
        check("rst_ctrl",  ctrl, CTRL_R);
        check("rst_irq",   32'(irq), 32'h0);
        areset = 1'b0;
        @(negedge aclk);

        // ---------------- directed table ----------------
        for (int i = 0; i < 22; i++) begin
            access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].be, '0,
                   wack, rack, err, rdata);
            check($sformatf("vec%0d_wrack", i), 32'(wack), 32'(vecs[i].e_wrack));
            check($sformatf("vec%0d_rdack", i), 32'(rack), 32'(vecs[i].e_rdack));
            check($sformatf("vec%0d_error", i), 32'(err),  32'(vecs[i].e_err));
            if (vecs[i].e_rdack) check($sformatf("vec%0d_data", i), rdata, vecs[i].e_data);
            @(negedge aclk);
            check($sformatf("vec%0d_ack_pulse", i), {30'h0, ip2bus_wrack, ip2bus_rdack}, 32'h0);
        end
        check("table_ctrl_out", ctrl, 32'h1234_0000);

        // ---------------- IRQ sequence ----------------
        do_reset();
        access(0, 0, 8'h00, 32'h0, 4'h0, 8'h05, wack, rack, err, rdata);
        check("irq_evt_noack", {30'h0, wack, rack}, 32'h0);
        access(1, 0, 8'h14, 32'h0000_0004, 4'b0001, '0, wack, rack, err, rdata);
        check("irq_en_lag", 32'(irq), 32'h0);
        @(negedge aclk);
        check("irq_en_set", 32'(irq), 32'h1);
        access(1, 0, 8'h10, 32'h0000_0004, 4'b0001, 8'h04, wack, rack, err, rdata);
        check("irq_w1c_race_ack", 32'(wack), 32'h1);
        @(negedge aclk);
        check("irq_w1c_race_irq", 32'(irq), 32'h1);
        access(0, 1, 8'h10, 32'h0, 4'h0, '0, wack, rack, err, rdata);
        check("irq_status_after_race", rdata, 32'h0000_0005);
        access(1, 0, 8'h10, 32'h0000_0004, 4'b0001, '0, wack, rack, err, rdata);
        check("irq_clr_lag", 32'(irq), 32'h1);
        @(negedge aclk);
        check("irq_clr_drop", 32'(irq), 32'h0);
        access(1, 0, 8'h10, 32'h0000_00FF, 4'b0000, '0, wack, rack, err, rdata);
        access(0, 1, 8'h10, 32'h0, 4'h0, '0, wack, rack, err, rdata);
        check("irq_status_final", rdata, 32'h0000_0001);

        // ---------------- write+read collision, request during ACK ----------------
        access(1, 1, 8'h08, 32'hCAFE_0123, 4'hF, '0, wack, rack, err, rdata);
        check("both_wrack", 32'(wack), 32'h1);
        check("both_rdack", 32'(rack), 32'h0);
        check("both_ctrl",  ctrl, 32'hCAFE_0123);
        @(negedge aclk);
        bus2ip_wr_req = 1'b1; bus2ip_addr = 8'h08; bus2ip_data = 32'h1111_1111; bus2ip_be = 4'hF;
        @(negedge aclk);
        check("busy_first_ack", 32'(ip2bus_wrack), 32'h1);
        bus2ip_data = 32'h2222_2222;   // still requesting during ACK
        @(negedge aclk);
        bus2ip_wr_req = 1'b0;
        check("busy_no_ack", {30'h0, ip2bus_wrack, ip2bus_rdack}, 32'h0);
        check("busy_ctrl",   ctrl, 32'h1111_1111);
        @(negedge aclk);
        check("busy_no_late_ack", {30'h0, ip2bus_wrack, ip2bus_rdack}, 32'h0);

        // ---------------- reset while in ACK ----------------
        @(negedge aclk);
        bus2ip_wr_req = 1'b1; bus2ip_addr = 8'h08; bus2ip_data = 32'h0F0F_0F0F; bus2ip_be = 4'hF;
        @(posedge aclk);
        #1;
        areset = 1'b1;
        bus2ip_wr_req = 1'b0;
        #1;
        check("rst_ack_suppressed", 32'(ip2bus_wrack), 32'h0);
        check("rst_ctrl_restored",  ctrl, CTRL_R);
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        check("rst_no_ack_after", {30'h0, ip2bus_wrack, ip2bus_rdack}, 32'h0);
        access(0, 1, 8'h00, 32'h0, 4'h0, '0, wack, rack, err, rdata);
        check("rst_then_read_ack",  32'(rack), 32'h1);
        check("rst_then_read_data", rdata, ID_V);

        // ---------------- randomized against the model ----------------
        do_reset();
        model_reset();
        for (int n = 0; n < 300; n++) begin
            bit          wr, rd;
            logic [7:0]  a;
            logic [31:0] d;
            logic [3:0]  be;
            logic [IW-1:0] ev;
            int          kind, pick;
            if ($urandom_range(0, 7) == 0) begin
                status = $urandom;
                repeat (2) @(negedge aclk);   // let a synchronized status settle
            end
            kind = $urandom_range(0, 3);
            wr   = (kind == 0) || (kind == 2);
            rd   = (kind != 0);
            pick = $urandom_range(0, 9);
            if (pick < 6)       a = 8'(pick * 4 + $urandom_range(0, 3));
            else if (pick == 6) a = 8'h40;
            else                a = 8'($urandom);
            d  = $urandom;
            be = 4'($urandom);
            ev = ($urandom_range(0, 3) == 0) ? IW'($urandom) : '0;
            model_access(wr, rd, a, d, be, ev, ew, er, ee, ed);
            access(wr, rd, a, d, be, ev, wack, rack, err, rdata);
            check("rnd_wrack", 32'(wack), 32'(ew));
            check("rnd_rdack", 32'(rack), 32'(er));
            check("rnd_error", 32'(err),  32'(ee));
            if (er) check($sformatf("rnd_data@%h", a), rdata, ed);
            @(negedge aclk);
            check("rnd_ack_pulse", {30'h0, ip2bus_wrack, ip2bus_rdack}, 32'h0);
            check("rnd_irq",  32'(irq), 32'(|(m_st & m_en)));
            check("rnd_ctrl", ctrl, m_ctrl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
